// File: rtl/ula_entrada_ctrl.sv
// ---------------------------------------------------------------------------
// ula_entrada_ctrl
//
// Input-capture stage that sits directly in front of the ULA datapath.
// The two active-low push buttons and the ten slide switches are brought
// into the clk domain through 2-FF synchronisers. Each button is debounced,
// and a 1->0 edge of the debounced level becomes a one-cycle press pulse.
// Press pulses update the registered operands and operation code, so the
// ULA always sees stable, glitch-free values.
//
//   KEY0 press             : step seletor 0,1,..,NUM_OPS-1,0,...
//   KEY1 press, sw[9] = 0  : a <= sw[3:0], b <= sw[7:4], carry_in <= sw[8]
//   KEY1 press, sw[9] = 1  : seletor <= sw[2:0] (codes >= NUM_OPS load 0)
//
// Ports
//   clk        in   1   system clock, all state on the rising edge
//   rst        in   1   synchronous reset, active-high
//   key_n      in   2   raw push buttons, active-low, asynchronous
//   sw         in   10  raw slide switches, asynchronous
//   a          out  4   registered operand A
//   b          out  4   registered operand B
//   carry_in   out  1   registered carry-in
//   seletor    out  3   registered operation code for the ULA mux
//   op_valid   out  1   one-cycle pulse in the cycle the outputs take a new value
//   dbg_state  out  2   per-key debounce FSM state (1 = PENDING)
//
// Handshake: there is no back-pressure. op_valid is a pure strobe that is
// high for exactly one cycle per update event, coincident with the new
// register values; the outputs hold their value whenever op_valid is low.
// ---------------------------------------------------------------------------
module ula_entrada_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int NUM_OPS         = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key_n,
  input  logic [9:0] sw,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       carry_in,
  output logic [2:0] seletor,
  output logic       op_valid,
  output logic [1:0] dbg_state
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_t;

  // Synchronisers
  logic [1:0]       r_key_s1;
  logic [1:0]       r_key_s2;
  logic [9:0]       r_sw_s1;
  logic [9:0]       r_sw_s2;

  // Debounce state, one lane per key
  db_state_t        r_state [2];
  logic [CNT_W-1:0] r_cnt   [2];
  logic [1:0]       r_db;
  logic [1:0]       r_db_prev;

  // Arming: a key only produces presses after it has been seen released
  // with a fully refilled synchroniser. This keeps a button that is held
  // down through reset from firing when reset drops.
  logic [1:0]       r_flush;
  logic [1:0]       r_arm;

  logic [1:0]       r_press;

  // Output registers
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic             r_carry;
  logic [2:0]       r_sel;
  logic             r_op_valid;

  // Combinational next values
  db_state_t        w_state_nxt [2];
  logic [CNT_W-1:0] w_cnt_nxt   [2];
  logic [1:0]       w_db_nxt;
  logic [1:0]       w_press;
  logic [2:0]       w_step_sel;
  logic [2:0]       w_direct_sel;

  // -------------------------------------------------------------------------
  // Input synchronisers. Keys reset to the released level (1) and switches
  // to 0 so that nothing looks like activity right after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_s1 <= 2'b11;
      r_key_s2 <= 2'b11;
      r_sw_s1  <= 10'd0;
      r_sw_s2  <= 10'd0;
    end else begin
      r_key_s1 <= key_n;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce FSM, next-state logic.
  // STABLE  : synced level equals debounced level, counter parked at 0.
  // PENDING : levels differ, counter runs. Reaching DEBOUNCE_CYCLES-1 while
  //           still different accepts the new level. Any return to the
  //           debounced level before that clears the count.
  // -------------------------------------------------------------------------
  always_comb begin
    w_db_nxt = r_db;
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (r_key_s2[i] == r_db[i]) begin
        w_state_nxt[i] = ST_STABLE;
        w_cnt_nxt[i]   = '0;
      end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        w_state_nxt[i] = ST_STABLE;
        w_cnt_nxt[i]   = '0;
        w_db_nxt[i]    = r_key_s2[i];
      end else begin
        w_state_nxt[i] = ST_PENDING;
        w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounce FSM, state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= ST_STABLE;
        r_cnt[i]   <= '0;
      end
      r_db      <= 2'b11;
      r_db_prev <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_db      <= w_db_nxt;
      r_db_prev <= r_db;
    end
  end

  assign dbg_state = {r_state[1] == ST_PENDING, r_state[0] == ST_PENDING};

  // -------------------------------------------------------------------------
  // Press detection. r_flush[1] rises once the synchroniser holds real
  // samples taken after reset; only then can a released key be armed.
  // The press pulse is registered before it drives the output registers.
  // -------------------------------------------------------------------------
  assign w_press = r_db_prev & ~r_db & r_arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush <= 2'b00;
      r_arm   <= 2'b00;
      r_press <= 2'b00;
    end else begin
      r_flush <= {r_flush[0], 1'b1};
      r_arm   <= r_arm | ({2{r_flush[1]}} & r_key_s2 & r_db);
      r_press <= w_press;
    end
  end

  // -------------------------------------------------------------------------
  // Output register update
  // -------------------------------------------------------------------------
  assign w_step_sel   = (r_sel == 3'(NUM_OPS - 1)) ? 3'd0 : r_sel + 3'd1;
  // Extra MSB so the comparison stays correct for any NUM_OPS up to 8.
  assign w_direct_sel = ({1'b0, r_sw_s2[2:0]} >= 4'(NUM_OPS)) ? 3'd0 : r_sw_s2[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= 4'd0;
      r_b        <= 4'd0;
      r_carry    <= 1'b0;
      r_sel      <= 3'd0;
      r_op_valid <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      if (r_press[1] && r_sw_s2[9]) begin
        // Direct operation load overrides a simultaneous KEY0 step.
        r_sel      <= w_direct_sel;
        r_op_valid <= 1'b1;
      end else begin
        if (r_press[1]) begin
          r_a     <= r_sw_s2[3:0];
          r_b     <= r_sw_s2[7:4];
          r_carry <= r_sw_s2[8];
        end
        if (r_press[0]) begin
          r_sel <= w_step_sel;
        end
        if (|r_press) begin
          r_op_valid <= 1'b1;
        end
      end
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign carry_in = r_carry;
  assign seletor  = r_sel;
  assign op_valid = r_op_valid;

endmodule

// File: tb/tb_ula_entrada_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ula_entrada_ctrl
//
// Directed bench for ula_entrada_ctrl with DEBOUNCE_CYCLES = 4. Stimulus
// pushes the hand-computed expected output word {seletor, carry_in, b, a}
// into exp_q for every press that must update the outputs; the monitor pops
// and compares each time op_valid is seen high.
// ---------------------------------------------------------------------------
module tb_ula_entrada_ctrl;

  localparam int DEB = 4;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic [9:0] sw;
  logic [3:0] a;
  logic [3:0] b;
  logic       carry_in;
  logic [2:0] seletor;
  logic       op_valid;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ula_entrada_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .NUM_OPS        (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .sw       (sw),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .seletor  (seletor),
    .op_valid (op_valid),
    .dbg_state(dbg_state)
  );

  // Bookkeeping
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_valid  = 0;
  int          edge_cnt = 0;
  int          last_valid_edge = 0;
  logic [11:0] exp_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [11:0] pk(input logic [2:0] s, input logic c,
                                     input logic [3:0] bb, input logic [3:0] aa);
    return {s, c, bb, aa};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (op_valid) begin
      n_valid++;
      last_valid_edge = edge_cnt;
      if (exp_q.size() == 0) begin
        check("unexpected_op_valid", {20'd0, seletor, carry_in, b, a}, 32'hFFFFFFFF);
      end else begin
        check("scoreboard_outputs", {20'd0, seletor, carry_in, b, a},
              {20'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] mask, input int low, input int high);
    key_n = ~mask;
    tick(low);
    key_n = 2'b11;
    tick(high);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick(1);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int v0;
  int t0;
  logic [2:0] step_tbl [7];

  initial begin
    step_tbl = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    key_n = 2'b00;
    sw    = 10'h3FF;
    rst   = 1'b1;

    // 1. Reset with keys held down and all switches on
    @(posedge clk); #1;
    tick(2);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_carry", carry_in, 0);
    check("rst_seletor", seletor, 0);
    check("rst_op_valid", op_valid, 0);
    rst = 1'b0;
    tick(20);
    check("t1_no_pulse_held", n_valid, 0);
    key_n = 2'b11;
    tick(12);
    check("t1_no_pulse_release", n_valid, 0);

    // 2. Operand load, latency
    sw = 10'h0B5;
    v0 = n_valid;
    exp_q.push_back(pk(3'd0, 1'b0, 4'hB, 4'h5));
    key_n = 2'b01;
    t0 = edge_cnt;
    tick(20);
    key_n = 2'b11;
    tick(10);
    wait_drain("t2_drain");
    check("t2_valid_count", n_valid - v0, 1);
    check("t2_latency", last_valid_edge - t0, DEB + 4);

    // 3. Stepping with wrap
    v0 = n_valid;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(pk(step_tbl[i], 1'b0, 4'hB, 4'h5));
      press(2'b01, 10, 10);
    end
    wait_drain("t3_drain");
    check("t3_valid_count", n_valid - v0, 7);
    check("t3_seletor_wrapped", seletor, 0);

    // 4. Glitches rejected, 4-cycle low accepted
    v0 = n_valid;
    press(2'b01, 1, 10);
    press(2'b01, 2, 10);
    press(2'b01, 3, 10);
    check("t4_glitch_no_valid", n_valid - v0, 0);
    check("t4_glitch_seletor", seletor, 0);
    exp_q.push_back(pk(3'd1, 1'b0, 4'hB, 4'h5));
    press(2'b01, 4, 10);
    wait_drain("t4_drain");
    check("t4_valid_count", n_valid - v0, 1);

    // 5. Direct operation load
    sw = 10'h207;
    exp_q.push_back(pk(3'd0, 1'b0, 4'hB, 4'h5));
    press(2'b10, 10, 10);
    sw = 10'h205;
    exp_q.push_back(pk(3'd5, 1'b0, 4'hB, 4'h5));
    press(2'b10, 10, 10);
    wait_drain("t5_drain");

    // 6. Simultaneous keys, operand load plus step
    sw = 10'h202;
    exp_q.push_back(pk(3'd2, 1'b0, 4'hB, 4'h5));
    press(2'b10, 10, 10);
    sw = 10'h1F3;
    v0 = n_valid;
    exp_q.push_back(pk(3'd3, 1'b1, 4'hF, 4'h3));
    press(2'b11, 10, 10);
    wait_drain("t6_drain");
    check("t6_valid_count", n_valid - v0, 1);

    // 7. Reset in the middle of a debounce count
    v0 = n_valid;
    key_n = 2'b10;
    tick(4);
    check("t7_pending_before_rst", dbg_state, 2'b01);
    rst = 1'b1;
    tick(2);
    check("t7_rst_outputs", {seletor, carry_in, b, a}, 12'd0);
    rst = 1'b0;
    tick(15);
    key_n = 2'b11;
    tick(15);
    check("t7_no_pulse", n_valid - v0, 0);
    check("t7_outputs_hold", {seletor, carry_in, b, a}, 12'd0);
    exp_q.push_back(pk(3'd1, 1'b0, 4'h0, 4'h0));
    press(2'b01, 10, 10);
    wait_drain("t7_drain");
    check("t7_valid_count", n_valid - v0, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
